// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Buffered UART transmitter: valid/ready byte FIFO feeding an 8N1
//            serialiser. Define UART_TX_PARITY_EN for an even-parity bit (8E1).
// Revision : 1.0
// ============================================================================

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [7:0]                  DATA,
    input  logic                        VALID,
    output logic                        READY,
    output logic                        UART_TXD,
    output logic                        BUSY,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
    output logic                        OVERFLOW
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_BW = $clog2(CLKS_PER_BIT);

    localparam logic [c_CW-1:0] c_FULL      = c_CW'(FIFO_DEPTH);
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_BAUD_ONE  = c_BW'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    // Reset asserts asynchronously but releases on a clock edge.
    logic r_rst_n_meta;
    logic r_rst_n_sync;
    logic w_rst_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rst_n_meta <= 1'b0;
            r_rst_n_sync <= 1'b0;
        end else begin
            r_rst_n_meta <= 1'b1;
            r_rst_n_sync <= r_rst_n_meta;
        end
    end

    assign w_rst_n = r_rst_n_sync;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] w_count_next;
    logic            r_ready;
    logic            r_overflow;
    logic            w_push;
    logic            w_pop;

    state_t          r_state;
    state_t          w_state_next;
    logic [c_BW-1:0] r_baud;
    logic [c_BW-1:0] w_baud_next;
    logic            w_baud_done;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_next;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic            r_txd;
    logic            w_txd_next;
    logic            r_busy;

    // READY is registered, so a full FIFO refuses a push even on a pop cycle.
    assign w_push       = VALID && r_ready;
    assign w_count_next = r_count + c_CW'(w_push) - c_CW'(w_pop);
    assign w_baud_done  = (r_baud == c_BAUD_LAST);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DATA;
        end
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != c_FULL);
            if (VALID && !r_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_idx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_baud_next  = '0;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_state_next = S_DATA;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                end else begin
                    w_baud_next = r_baud + c_BAUD_ONE;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + c_BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) begin
                    w_state_next = S_STOP;
                    w_baud_next  = '0;
                end else begin
                    w_baud_next = r_baud + c_BAUD_ONE;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when more bytes wait.
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_count != '0) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + c_BAUD_ONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
            end
        endcase
    end

    // Line level is computed for the upcoming state and registered.
    always_comb begin
        w_shift_next = w_pop ? r_mem[r_rd_ptr] : r_shift;
        w_txd_next   = 1'b1;
        case (w_state_next)
            S_IDLE:   w_txd_next = 1'b1;
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_shift_next[w_bit_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txd_next = ^w_shift_next;
`endif
            S_STOP:   w_txd_next = 1'b1;
            default:  w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_next;
            r_shift   <= w_shift_next;
            r_txd     <= w_txd_next;
            r_busy    <= (w_state_next != S_IDLE) || (w_count_next != '0);
        end
    end

    assign READY      = r_ready;
    assign UART_TXD   = r_txd;
    assign BUSY       = r_busy;
    assign FIFO_COUNT = r_count;
    assign OVERFLOW   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo with a line decoder.
// Revision : 1.0
// ============================================================================

module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CPB;

    logic       r_clk   = 1'b0;
    logic       r_rst_n = 1'b0;
    logic [7:0] r_data  = 8'h00;
    logic       r_valid = 1'b0;
    logic       w_ready;
    logic       w_txd;
    logic       w_busy;
    logic [2:0] w_count;
    logic       w_overflow;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         gap;
        bit         timing_ok;
        bit         busy_ok;
    } rx_t;

    rx_t rx_q[$];
    int  n_vec  = 0;
    int  n_fail = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLK       (r_clk),
        .RST_N     (r_rst_n),
        .DATA      (r_data),
        .VALID     (r_valid),
        .READY     (w_ready),
        .UART_TXD  (w_txd),
        .BUSY      (w_busy),
        .FIFO_COUNT(w_count),
        .OVERFLOW  (w_overflow)
    );

    always #5 r_clk = ~r_clk;

    // Line decoder: samples every cycle of each bit on the falling clock edge.
    initial begin : p_monitor
        int                    idle_cnt;
        logic [FRAME_BITS-1:0] bits;
        bit                    stable;
        bit                    busy_ok;
        bit                    aborted;
        rx_t                   f;
        idle_cnt = 0;
        forever begin
            @(negedge r_clk);
            if (!r_rst_n) begin
                idle_cnt = 0;
            end else if (w_txd === 1'b0) begin
                bits    = '0;
                stable  = 1'b1;
                busy_ok = 1'b1;
                aborted = 1'b0;
                for (int j = 0; j < FRAME_BITS && !aborted; j++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (j != 0 || c != 0) @(negedge r_clk);
                        if (!r_rst_n) begin
                            aborted = 1'b1;
                        end else begin
                            if (c == 0) bits[j] = w_txd;
                            else if (w_txd !== bits[j]) stable = 1'b0;
                            if (w_busy !== 1'b1) busy_ok = 1'b0;
                        end
                    end
                end
                if (!aborted) begin
                    f.data = bits[8:1];
`ifdef UART_TX_PARITY_EN
                    f.par = bits[9];
`else
                    f.par = 1'b0;
`endif
                    f.gap       = idle_cnt;
                    f.timing_ok = stable && (bits[0] === 1'b0) && (bits[FRAME_BITS-1] === 1'b1);
                    f.busy_ok   = busy_ok;
                    rx_q.push_back(f);
                end
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (rx_q.size() < n && cyc < budget) begin
            @(posedge r_clk);
            cyc++;
        end
        #1;
        check({tag, "_frames"}, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] exp, input int exp_gap);
        rx_t f;
        check({tag, "_present"}, 32'(rx_q.size() > 0), 32'd1);
        if (rx_q.size() == 0) return;
        f = rx_q.pop_front();
        check({tag, "_data"}, 32'(f.data), 32'(exp));
        check({tag, "_timing"}, 32'(f.timing_ok), 32'd1);
        check({tag, "_busy"}, 32'(f.busy_ok), 32'd1);
        if (exp_gap >= 0) check({tag, "_gap"}, 32'(f.gap), 32'(exp_gap));
`ifdef UART_TX_PARITY_EN
        check({tag, "_parity"}, 32'(f.par), 32'(^exp));
`endif
    endtask

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_stim
        int sent;
        int guard;
        int base;

        // Reset state
        r_rst_n = 1'b0;
        ticks(3);
        check("rst_txd", 32'(w_txd), 32'd1);
        check("rst_ready", 32'(w_ready), 32'd1);
        check("rst_busy", 32'(w_busy), 32'd0);
        check("rst_count", 32'(w_count), 32'd0);
        check("rst_ovf", 32'(w_overflow), 32'd0);
        r_rst_n = 1'b1;
        ticks(4);

        // Single byte 0xA5: latency, exact frame length, BUSY window
        r_data  = 8'hA5;
        r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        check("t1_count_push", 32'(w_count), 32'd1);
        check("t1_txd_pre", 32'(w_txd), 32'd1);
        check("t1_busy_push", 32'(w_busy), 32'd1);
        tick();
        check("t1_txd_start", 32'(w_txd), 32'd0);
        check("t1_count_pop", 32'(w_count), 32'd0);
        ticks(FRAME - 1);
        check("t1_txd_laststop", 32'(w_txd), 32'd1);
        check("t1_busy_laststop", 32'(w_busy), 32'd1);
        tick();
        check("t1_busy_done", 32'(w_busy), 32'd0);
        check("t1_txd_idle", 32'(w_txd), 32'd1);
        wait_frames("t1", 1, 20);
        expect_frame("t1", 8'hA5, -1);

        // Back-to-back 0x00, 0xFF, 0x55
        ticks(5);
        r_data  = 8'h00;
        r_valid = 1'b1;
        tick();
        check("t2_count_a", 32'(w_count), 32'd1);
        r_data = 8'hFF;
        tick();
        check("t2_count_b", 32'(w_count), 32'd1);
        r_data = 8'h55;
        tick();
        r_valid = 1'b0;
        check("t2_count_c", 32'(w_count), 32'd2);
        ticks(FRAME - 2);
        check("t2_count_f1end", 32'(w_count), 32'd2);
        tick();
        check("t2_count_f2start", 32'(w_count), 32'd1);
        ticks(FRAME);
        check("t2_count_f3start", 32'(w_count), 32'd0);
        check("t2_busy_f3", 32'(w_busy), 32'd1);
        wait_frames("t2", 3, 3 * FRAME);
        expect_frame("t2_f0", 8'h00, -1);
        expect_frame("t2_f1", 8'hFF, 0);
        expect_frame("t2_f2", 8'h55, 0);

        // Full FIFO and overflow: six pushes with VALID held
        ticks(5);
        r_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r_data = 8'(8'h10 + i);
            tick();
        end
        check("t3_count3", 32'(w_count), 32'd3);
        check("t3_ready3", 32'(w_ready), 32'd1);
        r_data = 8'h14;
        tick();
        check("t3_count_full", 32'(w_count), 32'd4);
        check("t3_ready_full", 32'(w_ready), 32'd0);
        check("t3_ovf_clear", 32'(w_overflow), 32'd0);
        r_data = 8'h15;
        tick();
        r_valid = 1'b0;
        check("t3_ovf_set", 32'(w_overflow), 32'd1);
        check("t3_count_drop", 32'(w_count), 32'd4);
        wait_frames("t3", 5, 6 * FRAME);
        check("t3_busy_end", 32'(w_busy), 32'd0);
        check("t3_ready_end", 32'(w_ready), 32'd1);
        check("t3_count_end", 32'(w_count), 32'd0);
        expect_frame("t3_f0", 8'h10, -1);
        for (int i = 1; i < 5; i++) begin
            expect_frame($sformatf("t3_f%0d", i), 8'(8'h10 + i), 0);
        end
        ticks(FRAME);
        check("t3_no_extra", 32'(rx_q.size()), 32'd0);

        // Pointer wrap: 3*DEPTH bytes pushed whenever READY
        ticks(5);
        sent  = 0;
        guard = 0;
        while (sent < 3 * DEPTH && guard < 3 * DEPTH * FRAME + 200) begin
            if (w_ready) begin
                r_data  = 8'(8'h30 + sent);
                r_valid = 1'b1;
                sent++;
            end else begin
                r_valid = 1'b0;
            end
            tick();
            guard++;
        end
        r_valid = 1'b0;
        check("t4_sent", 32'(sent), 32'(3 * DEPTH));
        wait_frames("t4", 3 * DEPTH, 6 * FRAME);
        ticks(2 * FRAME);
        check("t4_no_extra", 32'(rx_q.size()), 32'(3 * DEPTH));
        for (int i = 0; i < 3 * DEPTH; i++) begin
            expect_frame($sformatf("t4_f%0d", i), 8'(8'h30 + i), (i == 0) ? -1 : 0);
        end
        check("t4_ovf_sticky", 32'(w_overflow), 32'd1);

        // Reset during data bit 3 with two bytes queued
        ticks(5);
        r_valid = 1'b1;
        r_data  = 8'h40;
        tick();
        r_data = 8'h41;
        tick();
        r_data = 8'h42;
        tick();
        r_valid = 1'b0;
        check("t5_count_q", 32'(w_count), 32'd2);
        ticks(16);
        check("t5_busy_pre", 32'(w_busy), 32'd1);
        check("t5_txd_bit3", 32'(w_txd), 32'd0);
        base    = rx_q.size();
        r_rst_n = 1'b0;
        #1;
        check("t5_txd_rst", 32'(w_txd), 32'd1);
        check("t5_busy_rst", 32'(w_busy), 32'd0);
        check("t5_count_rst", 32'(w_count), 32'd0);
        check("t5_ovf_rst", 32'(w_overflow), 32'd0);
        ticks(2);
        r_rst_n = 1'b1;
        ticks(3 * FRAME);
        check("t5_no_frames", 32'(rx_q.size()), 32'(base));
        check("t5_txd_after", 32'(w_txd), 32'd1);
        check("t5_busy_after", 32'(w_busy), 32'd0);
        check("t5_count_after", 32'(w_count), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Parity: 0x07 -> 1, 0x03 -> 0, 11-bit frames
        ticks(5);
        r_data  = 8'h07;
        r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        tick();
        check("t6_txd_start", 32'(w_txd), 32'd0);
        ticks(4 * CPB + 4 * CPB + CPB);
        check("t6_parity_bit", 32'(w_txd), 32'd1);
        ticks(CPB - 1);
        ticks(CPB);
        check("t6_busy_laststop", 32'(w_busy), 32'd1);
        tick();
        check("t6_busy_done", 32'(w_busy), 32'd0);
        wait_frames("t6a", 1, 20);
        expect_frame("t6a", 8'h07, -1);
        r_data  = 8'h03;
        r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        wait_frames("t6b", 1, 2 * FRAME);
        expect_frame("t6b", 8'h03, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter. It is the transmit-side counterpart to the codebase's UART receiver.
- Accepts bytes over a valid/ready handshake into an internal FIFO.
- Serialises them on UART_TXD as 8N1 frames (LSB first), back-to-back with no idle gap.
- Sits between core/debug logic and the board TX pin, so producers never stall on bit timing.

Parameters:
CLKS_PER_BIT, 10417, clock cycles per bit (100 MHz / 9600 baud); legal range is 2 or more.
FIFO_DEPTH, 16, byte entries; must be a power of 2 and at least 2.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
DATA  input  8  byte to transmit.
VALID  input  1  DATA is valid this cycle.
READY  output  1  FIFO can accept a byte (not full).
UART_TXD  output  1  serial line; idles high.
BUSY  output  1  a frame is in progress or the FIFO is non-empty.
FIFO_COUNT  output  $clog2(FIFO_DEPTH)+1  bytes currently queued (excludes the byte being shifted).
OVERFLOW  output  1  sticky: VALID was asserted while READY was low.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - UART_TXD=1, READY=1, BUSY=0, FIFO_COUNT=0, OVERFLOW=0.
  - FSM goes to IDLE; FIFO pointers and bit counters are cleared.
- Reset mid-frame:
  - Line returns high immediately; the partial frame is abandoned.
  - Queued bytes are discarded.
- Handshake:
  - A byte is pushed at a rising edge where VALID and READY are both high.
  - READY = !full, registered from the FIFO count. It does not consider a same-cycle pop, so a full FIFO refuses a push even if a pop occurs that cycle.
  - VALID with READY low: the byte is dropped and OVERFLOW is set. OVERFLOW is cleared only by reset.
- FIFO:
  - Circular buffer with pointers of width $clog2(FIFO_DEPTH) that wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves FIFO_COUNT unchanged.
  - FIFO_COUNT saturates at FIFO_DEPTH because pushes are refused when full.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when enabled).
  - IDLE: UART_TXD=1. If FIFO_COUNT>0, pop the head into the shift register and go to START.
  - START: UART_TXD=0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
  - DATA: UART_TXD=shift[bit index] for CLKS_PER_BIT cycles per bit.
    - Bit index runs 0..7.
    - After bit 7, go to STOP (or PARITY when enabled).
  - STOP: UART_TXD=1 for CLKS_PER_BIT cycles.
    - At the last cycle, if FIFO is non-empty, pop and go directly to START (zero idle cycles between frames).
    - Otherwise go to IDLE.
- Timing:
  - Baud counter runs 0..CLKS_PER_BIT-1; every bit lasts exactly CLKS_PER_BIT cycles. A 10-bit frame is 10*CLKS_PER_BIT cycles.
  - UART_TXD is driven from a flop (glitch-free).
  - Latency: byte accepted at edge k into an empty FIFO with the FSM in IDLE, so UART_TXD falls at edge k+1.
- BUSY = (state != IDLE) || (FIFO_COUNT != 0). It deasserts at the same edge the FSM re-enters IDLE.
- DATA is sampled only at the push edge; later changes do not affect queued bytes.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, so a frame is 11*CLKS_PER_BIT cycles.
- Undefined: 8N1 only; no PARITY state or logic exists.

Test Plan:
1. Single byte (CLKS_PER_BIT=4): push 0xA5 from idle -> TXD low at the next edge, then bits 1,0,1,0,0,1,0,1, then high; 40 cycles total. BUSY is high for all 40 cycles, then 0.
2. Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles -> three frames with no high gap between the stop bit and the next start bit. FIFO_COUNT sequence is 1,1,2 after the pushes (first byte popped immediately), then decrements at each frame start.
3. Full/overflow (FIFO_DEPTH=4): push 6 bytes with VALID held -> READY drops once the FIFO is full; the 6th byte is dropped and OVERFLOW=1. Only the 5 accepted bytes appear on the line, in order.
4. Wrap-around: stream 3*FIFO_DEPTH bytes with an incrementing pattern, pushing while READY -> all bytes are transmitted in order with no loss or duplication.
5. Reset mid-frame: assert RST_N=0 during DATA bit 3 with 2 bytes queued -> TXD=1 and BUSY=0 immediately. After release, the line stays idle with no frames.
6. With UART_TX_PARITY_EN: push 0x07 -> parity bit 1 and a 44-cycle frame. Push 0x03 -> parity bit 0.
